gate_response_checker: RTL and testbench

//   Synthesizable self-checking sink for the NAND/NOR/XNOR gate block.
//   A stimulus source drives operands a/b; this block receives (a,b) with the gate outputs (c,d,e) over a valid/ready stream.

---
 rtl/gate_chk_pkg.sv | 23 ++
 rtl/gate_golden_model.sv | 22 ++
 rtl/gate_response_checker.sv | 132 +++++++++++++
 tb/tb_gate_response_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and the per-lane golden function for the gate response checker.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int C_BAD = 2;
   localparam int D_BAD = 1;
   localparam int E_BAD = 0;

   // One lane of reference results, packed as {nand, nor, xnor}
   function automatic logic [2:0] gate_golden(input logic a, input logic b);
      logic [2:0] g;
      g[C_BAD] = ~(a & b);
      g[D_BAD] = ~(a | b);
      g[E_BAD] = ~(a ^ b);
      return g;
   endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational WIDTH-wide NAND/NOR/XNOR reference used by the response checker.
module gate_golden_model
   import gate_chk_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] exp_c,
   output logic [WIDTH-1:0] exp_d,
   output logic [WIDTH-1:0] exp_e
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic [2:0] gold_s;
      assign gold_s   = gate_golden(a[i], b[i]);
      assign exp_c[i] = gold_s[C_BAD];
      assign exp_d[i] = gold_s[D_BAD];
      assign exp_e[i] = gold_s[E_BAD];
   end

endmodule

// File: rtl/gate_response_checker.sv
// Response sink for the gate block: checks each accepted sample against the
// golden model, counts samples and errors, and captures the first failure.
module gate_response_checker
   import gate_chk_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int NUM_SAMPLES = 10,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_c,
   input  logic [WIDTH-1:0] in_d,
   input  logic [WIDTH-1:0] in_e,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             err_pulse,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [2:0]       first_err_vec
);

   localparam logic [CNT_W-1:0] LAST_IDX = (NUM_SAMPLES == 0) ? {CNT_W{1'b0}} : CNT_W'(NUM_SAMPLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_e             state_r, next_state_s;
   logic               xfer_s, bad_s, clear_s;
   logic [2:0]         bad_vec_s;
   logic [WIDTH-1:0]   exp_c_s, exp_d_s, exp_e_s;
   logic               err_pulse_r;
   logic [CNT_W-1:0]   sample_cnt_r, err_cnt_r, first_err_idx_r;
   logic [2:0]         first_err_vec_r;

   gate_golden_model #(.WIDTH(WIDTH)) u_golden (
      .a     (in_a),
      .b     (in_b),
      .exp_c (exp_c_s),
      .exp_d (exp_d_s),
      .exp_e (exp_e_s)
   );

   assign xfer_s               = in_valid && (state_r == RUN);
   assign clear_s              = start && (state_r != RUN);
   assign bad_vec_s[C_BAD]     = |(in_c ^ exp_c_s);
   assign bad_vec_s[D_BAD]     = |(in_d ^ exp_d_s);
   assign bad_vec_s[E_BAD]     = |(in_e ^ exp_e_s);
   assign bad_s                = |bad_vec_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; a zero-sample run completes straight from start
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               next_state_s = (NUM_SAMPLES == 0) ? DONE : RUN;
            end else begin
               next_state_s = state_r;
            end
         end
         RUN: begin
            if (xfer_s && (sample_cnt_r == LAST_IDX)) begin
               next_state_s = DONE;
            end else begin
               next_state_s = RUN;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Handshake and status decode from state
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_r)
         RUN:     begin in_ready = 1'b1; busy = 1'b1; end
         DONE:    done = 1'b1;
         default: begin in_ready = 1'b0; busy = 1'b0; done = 1'b0; end
      endcase
      pass = done && (err_cnt_r == {CNT_W{1'b0}});
   end

   // Result counters and first-failure capture; a start outside RUN clears a run's results
   always_ff @(posedge clk) begin
      if (rst || clear_s) begin
         sample_cnt_r    <= {CNT_W{1'b0}};
         err_cnt_r       <= {CNT_W{1'b0}};
         first_err_idx_r <= {CNT_W{1'b0}};
         first_err_vec_r <= 3'b000;
         err_pulse_r     <= 1'b0;
      end else if (xfer_s) begin
         sample_cnt_r <= sample_cnt_r + CNT_W'(1);
         err_pulse_r  <= bad_s;
         if (bad_s) begin
            if (err_cnt_r != CNT_MAX) begin
               err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
            // err_cnt saturates instead of wrapping, so zero means no prior failure
            if (err_cnt_r == {CNT_W{1'b0}}) begin
               first_err_idx_r <= sample_cnt_r;
               first_err_vec_r <= bad_vec_s;
            end
         end
      end else begin
         err_pulse_r <= 1'b0;
      end
   end

   assign err_pulse     = err_pulse_r;
   assign sample_cnt    = sample_cnt_r;
   assign err_cnt       = err_cnt_r;
   assign first_err_idx = first_err_idx_r;
   assign first_err_vec = first_err_vec_r;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: a 10-sample build and a zero-sample build.
module tb_gate_response_checker;

   localparam int W  = 1;
   localparam int N  = 10;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst, start, start0, in_valid;
   logic [W-1:0]  in_a, in_b, in_c, in_d, in_e;

   logic          in_ready, busy, done, pass, err_pulse;
   logic [CW-1:0] sample_cnt, err_cnt, first_err_idx;
   logic [2:0]    first_err_vec;

   logic          in_ready0, busy0, done0, pass0, err_pulse0;
   logic [CW-1:0] sample_cnt0, err_cnt0, first_err_idx0;
   logic [2:0]    first_err_vec0;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   gate_response_checker #(.WIDTH(W), .NUM_SAMPLES(N), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
      .busy(busy), .done(done), .pass(pass), .err_pulse(err_pulse),
      .sample_cnt(sample_cnt), .err_cnt(err_cnt),
      .first_err_idx(first_err_idx), .first_err_vec(first_err_vec)
   );

   gate_response_checker #(.WIDTH(W), .NUM_SAMPLES(0), .CNT_W(CW)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_ready(in_ready0),
      .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
      .busy(busy0), .done(done0), .pass(pass0), .err_pulse(err_pulse0),
      .sample_cnt(sample_cnt0), .err_cnt(err_cnt0),
      .first_err_idx(first_err_idx0), .first_err_vec(first_err_vec0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miss_cnt++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic garbage();
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_c = W'($urandom);
      in_d = W'($urandom);
      in_e = W'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offer sample i (a=i[1], b=i[0]) with mask m flipping {c,d,e}, wait for acceptance
   task automatic send_idx(input int i, input logic [2:0] m);
      logic a, b;
      int   budget;
      a = i[1];
      b = i[0];
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_c = ~(a & b) ^ m[2];
      in_d = ~(a | b) ^ m[1];
      in_e = ~(a ^ b) ^ m[0];
      budget = 0;
      while (!in_ready && budget < 20) begin
         tick();
         budget++;
      end
      if (budget == 20) chk("ready_timeout", 32'd0, 32'd1);
      tick();
      in_valid = 1'b0;
      garbage();
   endtask

   task automatic run(input int f0, input logic [2:0] m0, input int f1, input logic [2:0] m1, input bit gaps);
      logic [2:0] m;
      int g;
      for (int i = 0; i < N; i++) begin
         m = (i == f0) ? m0 : ((i == f1) ? m1 : 3'b000);
         if (gaps) begin
            g = (i == 5) ? 1 : int'($urandom_range(0, 2));
            for (int k = 0; k < g; k++) begin
               in_valid = 1'b0;
               garbage();
               if (i == 5) start = 1'b1;
               tick();
               start = 1'b0;
               chk("gap_cnt", sample_cnt, i);
               chk("gap_pulse", err_pulse, 0);
               chk("gap_busy", busy, 1);
            end
         end
         send_idx(i, m);
         chk("cnt", sample_cnt, i + 1);
         chk("pulse", err_pulse, (m != 3'b000));
      end
      chk("ready_after", in_ready, 0);
      chk("busy_after", busy, 0);
      chk("done_after", done, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start0 = 1'b0; in_valid = 1'b0;
      in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0;
      tick();
      tick();
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_pulse", err_pulse, 0);
      chk("rst_cnt", sample_cnt, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_fidx", first_err_idx, 0);
      chk("rst_fvec", first_err_vec, 0);
      chk("rst_done0", done0, 0);
      rst = 1'b0;
      tick();

      // 1: all-correct run
      pulse_start();
      chk("t1_busy", busy, 1);
      chk("t1_ready", in_ready, 1);
      run(-1, 3'b000, -1, 3'b000, 1'b0);
      chk("t1_pass", pass, 1);
      chk("t1_cnt", sample_cnt, 10);
      chk("t1_err", err_cnt, 0);
      chk("t1_fidx", first_err_idx, 0);
      chk("t1_fvec", first_err_vec, 0);
      tick();
      chk("t1_pulse_low", err_pulse, 0);
      chk("t1_hold", done, 1);
      in_valid = 1'b1;
      garbage();
      tick();
      tick();
      in_valid = 1'b0;
      chk("t1_noready_cnt", sample_cnt, 10);

      // 2: single fault, sample 3 with c=1
      pulse_start();
      run(3, 3'b100, -1, 3'b000, 1'b0);
      chk("t2_pass", pass, 0);
      chk("t2_err", err_cnt, 1);
      chk("t2_fidx", first_err_idx, 3);
      chk("t2_fvec", first_err_vec, 3'b100);

      // 3: restart from DONE clears, then two faults
      pulse_start();
      chk("t3_clr_err", err_cnt, 0);
      chk("t3_clr_fidx", first_err_idx, 0);
      chk("t3_clr_fvec", first_err_vec, 0);
      chk("t3_clr_done", done, 0);
      run(2, 3'b010, 7, 3'b001, 1'b0);
      chk("t3_err", err_cnt, 2);
      chk("t3_fidx", first_err_idx, 2);
      chk("t3_fvec", first_err_vec, 3'b010);
      chk("t3_pass", pass, 0);

      // 4: gaps and an ignored mid-run start
      pulse_start();
      run(-1, 3'b000, -1, 3'b000, 1'b1);
      chk("t4_cnt", sample_cnt, 10);
      chk("t4_pass", pass, 1);

      // 5: reset after 4 samples (one bad) overrides start and a transfer
      pulse_start();
      for (int i = 0; i < 4; i++) send_idx(i, (i == 1) ? 3'b001 : 3'b000);
      chk("t5_pre_err", err_cnt, 1);
      rst = 1'b1;
      start = 1'b1;
      in_valid = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_ready", in_ready, 0);
      chk("t5_cnt", sample_cnt, 0);
      chk("t5_err", err_cnt, 0);
      chk("t5_fidx", first_err_idx, 0);
      chk("t5_fvec", first_err_vec, 0);
      tick();
      chk("t5_idle", busy, 0);
      pulse_start();
      run(-1, 3'b000, -1, 3'b000, 1'b0);
      chk("t5_pass", pass, 1);

      // 6: zero-sample build finishes one cycle after start
      chk("t6_pre_done0", done0, 0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("t6_done0", done0, 1);
      chk("t6_pass0", pass0, 1);
      chk("t6_busy0", busy0, 0);
      chk("t6_ready0", in_ready0, 0);
      chk("t6_cnt0", sample_cnt0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
